// File: rtl/axi_burst_checker.sv
// axi_burst_checker: passive AXI4 burst-integrity checker.
// Tracks AW/AR bursts against W/R beats, checks LAST placement and
// VALID/payload stability under stall, and exports sticky error flags,
// burst-done pulses and burst counters.
// Optional feature macro: AXI_STALL_COUNT_EN (per-channel stall-cycle counters).
module axi_burst_checker #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      axi_aw_valid,
  input  logic                      axi_aw_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr,
  input  logic [7:0]                axi_aw_len,
  input  logic                      axi_w_valid,
  input  logic                      axi_w_ready,
  input  logic                      axi_w_last,
  input  logic [AXI_DATA_WIDTH-1:0] axi_w_data,
  input  logic                      axi_ar_valid,
  input  logic                      axi_ar_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
  input  logic [7:0]                axi_ar_len,
  input  logic                      axi_r_valid,
  input  logic                      axi_r_ready,
  input  logic                      axi_r_last,
  input  logic [AXI_DATA_WIDTH-1:0] axi_r_data,
  output logic                      wr_burst_done,
  output logic                      rd_burst_done,
  output logic [CNT_WIDTH-1:0]      wr_burst_count,
  output logic [CNT_WIDTH-1:0]      rd_burst_count,
  output logic [7:0]                err_flags,
  output logic                      err_any
`ifdef AXI_STALL_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]      aw_stall_cycles,
  output logic [CNT_WIDTH-1:0]      w_stall_cycles,
  output logic [CNT_WIDTH-1:0]      ar_stall_cycles,
  output logic [CNT_WIDTH-1:0]      r_stall_cycles
`endif
);

  localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W    = PTR_W + 1;
  localparam int unsigned AW_PAY_W = AXI_ADDR_WIDTH + 8;
  localparam int unsigned W_PAY_W  = AXI_DATA_WIDTH + 1;
  localparam int unsigned PAY_W    = (AW_PAY_W > W_PAY_W) ? AW_PAY_W : W_PAY_W;
  localparam int unsigned NDIR     = 2;  // 0 = write, 1 = read
  localparam int unsigned NCH      = 4;  // 0 = AW, 1 = W, 2 = AR, 3 = R

  // Per-direction view of the address and beat channels
  logic [NDIR-1:0]  addr_hs_c;
  logic [NDIR-1:0]  beat_hs_c;
  logic [NDIR-1:0]  beat_last_c;
  logic [7:0]       addr_len_c [NDIR];

  // Per-channel view for the stability monitor
  logic [NCH-1:0]   ch_vld_c;
  logic [NCH-1:0]   ch_rdy_c;
  logic [PAY_W-1:0] ch_pay_c [NCH];

  assign addr_hs_c   = {axi_ar_valid && axi_ar_ready, axi_aw_valid && axi_aw_ready};
  assign beat_hs_c   = {axi_r_valid && axi_r_ready, axi_w_valid && axi_w_ready};
  assign beat_last_c = {axi_r_last, axi_w_last};
  assign addr_len_c[0] = axi_aw_len;
  assign addr_len_c[1] = axi_ar_len;

  assign ch_vld_c = {axi_r_valid, axi_ar_valid, axi_w_valid, axi_aw_valid};
  assign ch_rdy_c = {axi_r_ready, axi_ar_ready, axi_w_ready, axi_aw_ready};
  assign ch_pay_c[0] = PAY_W'({axi_aw_addr, axi_aw_len});
  assign ch_pay_c[1] = PAY_W'({axi_w_data, axi_w_last});
  assign ch_pay_c[2] = PAY_W'({axi_ar_addr, axi_ar_len});
  assign ch_pay_c[3] = PAY_W'({axi_r_data, axi_r_last});

  // Burst-length FIFOs and beat counters
  logic [7:0]           fifo_q     [NDIR][FIFO_DEPTH];
  logic [7:0]           fifo_d     [NDIR][FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q   [NDIR];
  logic [PTR_W-1:0]     rd_ptr_d   [NDIR];
  logic [PTR_W-1:0]     wr_ptr_q   [NDIR];
  logic [PTR_W-1:0]     wr_ptr_d   [NDIR];
  logic [OCC_W-1:0]     occ_q      [NDIR];
  logic [OCC_W-1:0]     occ_d      [NDIR];
  logic [7:0]           beat_cnt_q [NDIR];
  logic [7:0]           beat_cnt_d [NDIR];

  // Reported state
  logic [NDIR-1:0]      done_q;
  logic [NDIR-1:0]      done_d;
  logic [CNT_WIDTH-1:0] burst_cnt_q [NDIR];
  logic [CNT_WIDTH-1:0] burst_cnt_d [NDIR];
  logic [7:0]           err_flags_q;
  logic [7:0]           err_flags_d;
  logic                 err_any_q;
  logic                 err_any_d;

  // Stability monitor state
  logic [NCH-1:0]       stall_q;
  logic [NCH-1:0]       stall_d;
  logic [PAY_W-1:0]     pay_q [NCH];
  logic [PAY_W-1:0]     pay_d [NCH];

  logic [NDIR-1:0]      close_c;
  logic [NDIR-1:0]      push_c;
  logic [NDIR-1:0]      pop_c;
  logic [NDIR-1:0]      head_vld_c;
  logic [7:0]           head_len_c [NDIR];
  logic [7:0]           err_set_c;
  logic                 stab_err_c;

  // Burst tracking: match beats to the FIFO head (or a same-cycle bypass), push/pop lengths
  always_comb begin
    close_c    = '0;
    push_c     = '0;
    pop_c      = '0;
    head_vld_c = '0;
    err_set_c  = '0;
    fifo_d     = fifo_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    beat_cnt_d = beat_cnt_q;
    for (int d = 0; d < NDIR; d++) begin
      head_vld_c[d] = (occ_q[d] != '0) || addr_hs_c[d];
      head_len_c[d] = (occ_q[d] == '0) ? addr_len_c[d] : fifo_q[d][rd_ptr_q[d]];
      if (beat_hs_c[d]) begin
        if (!head_vld_c[d]) begin
          err_set_c[4+d] = 1'b1;
        end else if (beat_cnt_q[d] == head_len_c[d]) begin
          if (!beat_last_c[d]) err_set_c[2*d] = 1'b1;
          close_c[d] = 1'b1;
        end else if (beat_last_c[d]) begin
          err_set_c[2*d+1] = 1'b1;
          close_c[d]       = 1'b1;
        end else begin
          beat_cnt_d[d] = beat_cnt_q[d] + 8'd1;
        end
      end
      if (close_c[d]) beat_cnt_d[d] = '0;
      // A bypassed burst that closes in its own AW/AR cycle never enters the FIFO
      pop_c[d]  = close_c[d] && (occ_q[d] != '0);
      push_c[d] = addr_hs_c[d] && !(close_c[d] && (occ_q[d] == '0));
      if (push_c[d] && !pop_c[d] && (occ_q[d] == OCC_W'(FIFO_DEPTH))) begin
        err_set_c[6] = 1'b1;
        push_c[d]    = 1'b0;
      end
      if (push_c[d]) begin
        fifo_d[d][wr_ptr_q[d]] = addr_len_c[d];
        wr_ptr_d[d]            = wr_ptr_q[d] + PTR_W'(1);
      end
      if (pop_c[d]) rd_ptr_d[d] = rd_ptr_q[d] + PTR_W'(1);
      if (push_c[d] && !pop_c[d]) begin
        occ_d[d] = occ_q[d] + OCC_W'(1);
      end else if (pop_c[d] && !push_c[d]) begin
        occ_d[d] = occ_q[d] - OCC_W'(1);
      end
    end
  end

  // Stability check and event recording; clear suppresses same-cycle events
  always_comb begin
    stall_d     = ch_vld_c & ~ch_rdy_c;
    pay_d       = ch_pay_c;
    stab_err_c  = 1'b0;
    err_flags_d = err_flags_q;
    burst_cnt_d = burst_cnt_q;
    done_d      = '0;
    for (int c = 0; c < NCH; c++) begin
      if (stall_q[c] && (!ch_vld_c[c] || (ch_pay_c[c] != pay_q[c]))) stab_err_c = 1'b1;
    end
    if (clear) begin
      err_flags_d = '0;
      for (int d = 0; d < NDIR; d++) burst_cnt_d[d] = '0;
    end else begin
      err_flags_d = err_flags_q | err_set_c | {stab_err_c, 7'b0};
      done_d      = close_c;
      for (int d = 0; d < NDIR; d++) begin
        if (close_c[d]) burst_cnt_d[d] = burst_cnt_q[d] + CNT_WIDTH'(1);
      end
    end
    err_any_d = |err_flags_d;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < NDIR; d++) begin
        for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[d][i] <= '0;
        rd_ptr_q[d]    <= '0;
        wr_ptr_q[d]    <= '0;
        occ_q[d]       <= '0;
        beat_cnt_q[d]  <= '0;
        burst_cnt_q[d] <= '0;
      end
      for (int c = 0; c < NCH; c++) pay_q[c] <= '0;
      done_q      <= '0;
      err_flags_q <= '0;
      err_any_q   <= 1'b0;
      stall_q     <= '0;
    end else begin
      fifo_q      <= fifo_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      pay_q       <= pay_d;
      done_q      <= done_d;
      err_flags_q <= err_flags_d;
      err_any_q   <= err_any_d;
      stall_q     <= stall_d;
    end
  end

  assign wr_burst_done  = done_q[0];
  assign rd_burst_done  = done_q[1];
  assign wr_burst_count = burst_cnt_q[0];
  assign rd_burst_count = burst_cnt_q[1];
  assign err_flags      = err_flags_q;
  assign err_any        = err_any_q;

`ifdef AXI_STALL_COUNT_EN
  logic [CNT_WIDTH-1:0] stall_cyc_q [NCH];
  logic [CNT_WIDTH-1:0] stall_cyc_d [NCH];

  // Saturating per-channel stall-cycle counters
  always_comb begin
    stall_cyc_d = stall_cyc_q;
    for (int c = 0; c < NCH; c++) begin
      if (clear) begin
        stall_cyc_d[c] = '0;
      end else if (ch_vld_c[c] && !ch_rdy_c[c] && (stall_cyc_q[c] != '1)) begin
        stall_cyc_d[c] = stall_cyc_q[c] + CNT_WIDTH'(1);
      end
    end
  end

  // Stall counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) stall_cyc_q[c] <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
    end
  end

  assign aw_stall_cycles = stall_cyc_q[0];
  assign w_stall_cycles  = stall_cyc_q[1];
  assign ar_stall_cycles = stall_cyc_q[2];
  assign r_stall_cycles  = stall_cyc_q[3];
`endif

endmodule

// File: tb/tb_axi_burst_checker.sv
// tb_axi_burst_checker: directed scenarios plus randomized traffic checked
// against a queue-based burst model.
`timescale 1ns/1ps
module tb_axi_burst_checker;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 32;

  logic          clk = 1'b0;
  logic          rst, clear;
  logic          aw_valid, aw_ready, w_valid, w_ready, w_last;
  logic          ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [AW-1:0] aw_addr, ar_addr;
  logic [7:0]    aw_len, ar_len;
  logic [DW-1:0] w_data, r_data;
  logic          wr_burst_done, rd_burst_done, err_any;
  logic [CW-1:0] wr_burst_count, rd_burst_count;
  logic [7:0]    err_flags;
`ifdef AXI_STALL_COUNT_EN
  logic [CW-1:0] aw_stall_cycles, w_stall_cycles, ar_stall_cycles, r_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_burst_checker #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .axi_aw_valid(aw_valid), .axi_aw_ready(aw_ready), .axi_aw_addr(aw_addr), .axi_aw_len(aw_len),
    .axi_w_valid(w_valid), .axi_w_ready(w_ready), .axi_w_last(w_last), .axi_w_data(w_data),
    .axi_ar_valid(ar_valid), .axi_ar_ready(ar_ready), .axi_ar_addr(ar_addr), .axi_ar_len(ar_len),
    .axi_r_valid(r_valid), .axi_r_ready(r_ready), .axi_r_last(r_last), .axi_r_data(r_data),
    .wr_burst_done(wr_burst_done), .rd_burst_done(rd_burst_done),
    .wr_burst_count(wr_burst_count), .rd_burst_count(rd_burst_count),
    .err_flags(err_flags), .err_any(err_any)
`ifdef AXI_STALL_COUNT_EN
    , .aw_stall_cycles(aw_stall_cycles), .w_stall_cycles(w_stall_cycles),
    .ar_stall_cycles(ar_stall_cycles), .r_stall_cycles(r_stall_cycles)
`endif
  );

  // Reference model state (burst level)
  logic [7:0]  wq[$];
  logic [7:0]  rq[$];
  int          mcnt [2];
  logic [7:0]  mflags;
  logic [31:0] mcount [2];
  bit          mdone [2];
  bit          mst [4];
  logic [63:0] mpay [4];
  logic [31:0] mstc [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 1'b0;
    aw_valid = 1'b0; aw_ready = 1'b0; aw_addr = '0; aw_len = '0;
    w_valid = 1'b0; w_ready = 1'b0; w_last = 1'b0; w_data = '0;
    ar_valid = 1'b0; ar_ready = 1'b0; ar_addr = '0; ar_len = '0;
    r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0; r_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic int qsize(int d);
    return (d == 0) ? wq.size() : rq.size();
  endfunction

  function automatic logic [7:0] qfront(int d);
    return (d == 0) ? wq[0] : rq[0];
  endfunction

  function automatic void qpush(int d, logic [7:0] v);
    if (d == 0) wq.push_back(v);
    else rq.push_back(v);
  endfunction

  function automatic void qpop(int d);
    logic [7:0] t;
    if (d == 0) t = wq.pop_front();
    else t = rq.pop_front();
  endfunction

  // One direction of the model: outstanding lengths in a queue, beats counted against the oldest
  task automatic model_dir(input int d, input bit ah, input logic [7:0] alen, input bit bh,
                           input bit last, output bit close, output logic [7:0] set);
    bit pushed;
    close = 1'b0; set = '0; pushed = 1'b0;
    if (ah && qsize(d) == 0) begin
      qpush(d, alen);
      pushed = 1'b1;
    end
    if (bh) begin
      if (qsize(d) == 0) begin
        set[4+d] = 1'b1;
      end else begin
        if (mcnt[d] == int'(qfront(d))) begin
          if (!last) set[2*d] = 1'b1;
          close = 1'b1;
        end else if (last) begin
          set[2*d+1] = 1'b1;
          close = 1'b1;
        end else begin
          mcnt[d]++;
        end
        if (close) begin
          qpop(d);
          mcnt[d] = 0;
        end
      end
    end
    if (ah && !pushed) begin
      if (qsize(d) < int'(DEPTH)) qpush(d, alen);
      else set[6] = 1'b1;
    end
  endtask

  task automatic model_reset();
    wq.delete(); rq.delete();
    mflags = '0;
    for (int d = 0; d < 2; d++) begin mcnt[d] = 0; mcount[d] = '0; mdone[d] = 1'b0; end
    for (int c = 0; c < 4; c++) begin mst[c] = 1'b0; mpay[c] = '0; mstc[c] = '0; end
  endtask

  // Advance the model by one clock using the currently driven inputs
  task automatic model_step();
    bit cw, cr, s7;
    logic [7:0] sw, sr;
    bit v [4];
    bit r [4];
    logic [63:0] p [4];
    model_dir(0, aw_valid && aw_ready, aw_len, w_valid && w_ready, w_last, cw, sw);
    model_dir(1, ar_valid && ar_ready, ar_len, r_valid && r_ready, r_last, cr, sr);
    v[0] = aw_valid; v[1] = w_valid; v[2] = ar_valid; v[3] = r_valid;
    r[0] = aw_ready; r[1] = w_ready; r[2] = ar_ready; r[3] = r_ready;
    p[0] = 64'({aw_addr, aw_len}); p[1] = 64'({w_data, w_last});
    p[2] = 64'({ar_addr, ar_len}); p[3] = 64'({r_data, r_last});
    s7 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (mst[c] && (!v[c] || p[c] != mpay[c])) s7 = 1'b1;
      mst[c]  = v[c] && !r[c];
      mpay[c] = p[c];
    end
    if (clear) begin
      mflags = '0;
      for (int d = 0; d < 2; d++) begin mcount[d] = '0; mdone[d] = 1'b0; end
      for (int c = 0; c < 4; c++) mstc[c] = '0;
    end else begin
      mflags = mflags | sw | sr | {s7, 7'b0};
      mdone[0] = cw; mdone[1] = cr;
      if (cw) mcount[0] = mcount[0] + 32'd1;
      if (cr) mcount[1] = mcount[1] + 32'd1;
      for (int c = 0; c < 4; c++) if (v[c] && !r[c] && mstc[c] != '1) mstc[c] = mstc[c] + 32'd1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (wr_burst_done !== 1'b0) begin errors++; $display("FAIL reset_wr_done got %b exp 0", wr_burst_done); end
    checks++; if (rd_burst_done !== 1'b0) begin errors++; $display("FAIL reset_rd_done got %b exp 0", rd_burst_done); end
    checks++; if (wr_burst_count !== 32'd0) begin errors++; $display("FAIL reset_wr_count got %0d exp 0", wr_burst_count); end
    checks++; if (rd_burst_count !== 32'd0) begin errors++; $display("FAIL reset_rd_count got %0d exp 0", rd_burst_count); end
    checks++; if (err_flags !== 8'h00) begin errors++; $display("FAIL reset_flags got %h exp 00", err_flags); end
    checks++; if (err_any !== 1'b0) begin errors++; $display("FAIL reset_err_any got %b exp 0", err_any); end
  endtask

  task automatic test_write_ok();
    do_reset();
    aw_valid = 1'b1; aw_ready = 1'b1; aw_len = 8'd3; aw_addr = 32'h40;
    tick();
    aw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_valid = 1'b1; w_ready = 1'b1; w_last = (i == 3); w_data = $urandom;
      tick();
      if (i == 2) begin
        checks++; if (wr_burst_done !== 1'b0) begin errors++; $display("FAIL wr_ok_early_done got %b exp 0", wr_burst_done); end
      end
    end
    w_valid = 1'b0; w_last = 1'b0;
    checks++; if (wr_burst_done !== 1'b1) begin errors++; $display("FAIL wr_ok_done got %b exp 1", wr_burst_done); end
    checks++; if (wr_burst_count !== 32'd1) begin errors++; $display("FAIL wr_ok_count got %0d exp 1", wr_burst_count); end
    checks++; if (err_flags !== 8'h00) begin errors++; $display("FAIL wr_ok_flags got %h exp 00", err_flags); end
    tick();
    checks++; if (wr_burst_done !== 1'b0) begin errors++; $display("FAIL wr_ok_pulse_width got %b exp 0", wr_burst_done); end
  endtask

  task automatic test_read_errors();
    do_reset();
    ar_valid = 1'b1; ar_ready = 1'b1; ar_len = 8'd1;
    tick();
    ar_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      r_valid = 1'b1; r_ready = 1'b1; r_last = 1'b0; r_data = $urandom;
      tick();
    end
    r_valid = 1'b0;
    checks++; if (err_flags !== 8'h04) begin errors++; $display("FAIL rlast_missing_flags got %h exp 04", err_flags); end
    checks++; if (rd_burst_count !== 32'd1) begin errors++; $display("FAIL rlast_missing_count got %0d exp 1", rd_burst_count); end
    checks++; if (rd_burst_done !== 1'b1) begin errors++; $display("FAIL rlast_missing_done got %b exp 1", rd_burst_done); end
    checks++; if (err_any !== 1'b1) begin errors++; $display("FAIL rlast_missing_any got %b exp 1", err_any); end
    ar_valid = 1'b1; ar_ready = 1'b1; ar_len = 8'd3;
    tick();
    ar_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      r_valid = 1'b1; r_ready = 1'b1; r_last = (i == 1); r_data = $urandom;
      tick();
    end
    r_valid = 1'b0; r_last = 1'b0;
    checks++; if (err_flags !== 8'h0C) begin errors++; $display("FAIL rlast_early_flags got %h exp 0c", err_flags); end
    checks++; if (rd_burst_count !== 32'd2) begin errors++; $display("FAIL rlast_early_count got %0d exp 2", rd_burst_count); end
    checks++; if (wr_burst_count !== 32'd0) begin errors++; $display("FAIL rlast_early_wr_count got %0d exp 0", wr_burst_count); end
  endtask

  task automatic test_bypass_and_orphan();
    do_reset();
    aw_valid = 1'b1; aw_ready = 1'b1; aw_len = 8'd0;
    w_valid = 1'b1; w_ready = 1'b1; w_last = 1'b1;
    tick();
    aw_valid = 1'b0;
    checks++; if (err_flags !== 8'h00) begin errors++; $display("FAIL bypass_flags got %h exp 00", err_flags); end
    checks++; if (wr_burst_count !== 32'd1) begin errors++; $display("FAIL bypass_count got %0d exp 1", wr_burst_count); end
    tick();
    w_valid = 1'b0; w_last = 1'b0;
    checks++; if (err_flags !== 8'h10) begin errors++; $display("FAIL orphan_w_flags got %h exp 10", err_flags); end
    checks++; if (wr_burst_count !== 32'd1) begin errors++; $display("FAIL orphan_w_count got %0d exp 1", wr_burst_count); end
    checks++; if (wr_burst_done !== 1'b0) begin errors++; $display("FAIL orphan_w_done got %b exp 0", wr_burst_done); end
  endtask

  task automatic test_overflow();
    do_reset();
    aw_ready = 1'b1; aw_len = 8'd0;
    for (int i = 0; i < 9; i++) begin
      aw_valid = 1'b1; aw_addr = 32'(i * 4);
      tick();
      if (i == 7) begin
        checks++; if (err_flags !== 8'h00) begin errors++; $display("FAIL ovf_at_full_flags got %h exp 00", err_flags); end
      end
    end
    aw_valid = 1'b0;
    checks++; if (err_flags !== 8'h40) begin errors++; $display("FAIL ovf_flags got %h exp 40", err_flags); end
    for (int i = 0; i < 8; i++) begin
      w_valid = 1'b1; w_ready = 1'b1; w_last = 1'b1;
      tick();
    end
    checks++; if (wr_burst_count !== 32'd8) begin errors++; $display("FAIL ovf_drain_count got %0d exp 8", wr_burst_count); end
    checks++; if (err_flags !== 8'h40) begin errors++; $display("FAIL ovf_drain_flags got %h exp 40", err_flags); end
    tick();
    w_valid = 1'b0; w_last = 1'b0;
    checks++; if (err_flags !== 8'h50) begin errors++; $display("FAIL ovf_dropped_flags got %h exp 50", err_flags); end
  endtask

  task automatic test_stability();
    do_reset();
    aw_valid = 1'b1; aw_ready = 1'b0; aw_addr = 32'h100; aw_len = 8'd0;
    tick();
    aw_addr = 32'h104;
    tick();
    checks++; if (err_flags !== 8'h80) begin errors++; $display("FAIL stab_addr_flags got %h exp 80", err_flags); end
    do_reset();
    w_valid = 1'b1; w_ready = 1'b0; w_data = 32'hA5A5_0001;
    tick();
    w_valid = 1'b0;
    tick();
    checks++; if (err_flags !== 8'h80) begin errors++; $display("FAIL stab_wvalid_drop_flags got %h exp 80", err_flags); end
    do_reset();
    aw_valid = 1'b1; aw_ready = 1'b0; aw_addr = 32'h200; aw_len = 8'd0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (err_flags !== 8'h00) begin errors++; $display("FAIL stab_held_flags got %h exp 00", err_flags); end
`ifdef AXI_STALL_COUNT_EN
    checks++; if (aw_stall_cycles !== 32'd5) begin errors++; $display("FAIL aw_stall_cycles got %0d exp 5", aw_stall_cycles); end
`endif
    aw_ready = 1'b1;
    tick();
    aw_valid = 1'b0;
    checks++; if (err_flags !== 8'h00) begin errors++; $display("FAIL stab_release_flags got %h exp 00", err_flags); end
  endtask

  task automatic test_clear();
    do_reset();
    aw_valid = 1'b1; aw_ready = 1'b1; aw_len = 8'd0;
    w_valid = 1'b1; w_ready = 1'b1; w_last = 1'b1;
    tick();
    aw_valid = 1'b0;
    tick();
    checks++; if (err_flags !== 8'h10) begin errors++; $display("FAIL clear_pre_flags got %h exp 10", err_flags); end
    clear = 1'b1;
    tick();
    clear = 1'b0; w_valid = 1'b0; w_last = 1'b0;
    checks++; if (err_flags !== 8'h00) begin errors++; $display("FAIL clear_flags got %h exp 00", err_flags); end
    checks++; if (wr_burst_count !== 32'd0) begin errors++; $display("FAIL clear_count got %0d exp 0", wr_burst_count); end
    checks++; if (err_any !== 1'b0) begin errors++; $display("FAIL clear_err_any got %b exp 0", err_any); end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    aw_valid = 1'b1; aw_ready = 1'b1; aw_len = 8'd3;
    tick();
    aw_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w_valid = 1'b1; w_ready = 1'b1; w_last = 1'b0;
      tick();
    end
    w_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (wr_burst_count !== 32'd0 || wr_burst_done !== 1'b0) begin errors++; $display("FAIL midrst_wr got count %0d done %b exp 0 0", wr_burst_count, wr_burst_done); end
    checks++; if (err_flags !== 8'h00 || err_any !== 1'b0) begin errors++; $display("FAIL midrst_flags got %h any %b exp 00 0", err_flags, err_any); end
    aw_valid = 1'b1; aw_ready = 1'b1; aw_len = 8'd1;
    tick();
    aw_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w_valid = 1'b1; w_ready = 1'b1; w_last = (i == 1);
      tick();
    end
    w_valid = 1'b0; w_last = 1'b0;
    checks++; if (wr_burst_count !== 32'd1) begin errors++; $display("FAIL midrst_fresh_count got %0d exp 1", wr_burst_count); end
    checks++; if (err_flags !== 8'h00) begin errors++; $display("FAIL midrst_fresh_flags got %h exp 00", err_flags); end
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      if (!(mst[0] && $urandom_range(0, 19) != 0)) begin
        aw_valid = ($urandom_range(0, 2) == 0); aw_addr = $urandom; aw_len = 8'($urandom_range(0, 3));
      end
      aw_ready = 1'($urandom_range(0, 1));
      if (!(mst[2] && $urandom_range(0, 19) != 0)) begin
        ar_valid = ($urandom_range(0, 2) == 0); ar_addr = $urandom; ar_len = 8'($urandom_range(0, 3));
      end
      ar_ready = 1'($urandom_range(0, 1));
      if (!(mst[1] && $urandom_range(0, 19) != 0)) begin
        w_valid = ($urandom_range(0, 3) != 0) && (wq.size() != 0 || $urandom_range(0, 9) == 0);
        w_data  = $urandom;
        w_last  = (wq.size() != 0) && (mcnt[0] == int'(wq[0]));
        if ($urandom_range(0, 9) == 0) w_last = ~w_last;
      end
      w_ready = 1'($urandom_range(0, 1));
      if (!(mst[3] && $urandom_range(0, 19) != 0)) begin
        r_valid = ($urandom_range(0, 3) != 0) && (rq.size() != 0 || $urandom_range(0, 9) == 0);
        r_data  = $urandom;
        r_last  = (rq.size() != 0) && (mcnt[1] == int'(rq[0]));
        if ($urandom_range(0, 9) == 0) r_last = ~r_last;
      end
      r_ready = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 49) == 0);
      model_step();
      tick();
      checks++; if (wr_burst_done !== mdone[0]) begin errors++; $display("FAIL rand_wr_done cyc %0d got %b exp %b", n, wr_burst_done, mdone[0]); end
      checks++; if (rd_burst_done !== mdone[1]) begin errors++; $display("FAIL rand_rd_done cyc %0d got %b exp %b", n, rd_burst_done, mdone[1]); end
      checks++; if (wr_burst_count !== mcount[0]) begin errors++; $display("FAIL rand_wr_count cyc %0d got %0d exp %0d", n, wr_burst_count, mcount[0]); end
      checks++; if (rd_burst_count !== mcount[1]) begin errors++; $display("FAIL rand_rd_count cyc %0d got %0d exp %0d", n, rd_burst_count, mcount[1]); end
      checks++; if (err_flags !== mflags) begin errors++; $display("FAIL rand_flags cyc %0d got %h exp %h", n, err_flags, mflags); end
      checks++; if (err_any !== (|mflags)) begin errors++; $display("FAIL rand_err_any cyc %0d got %b exp %b", n, err_any, |mflags); end
`ifdef AXI_STALL_COUNT_EN
      checks++; if (w_stall_cycles !== mstc[1]) begin errors++; $display("FAIL rand_w_stall cyc %0d got %0d exp %0d", n, w_stall_cycles, mstc[1]); end
      checks++; if (ar_stall_cycles !== mstc[2]) begin errors++; $display("FAIL rand_ar_stall cyc %0d got %0d exp %0d", n, ar_stall_cycles, mstc[2]); end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_write_ok();
    test_read_errors();
    test_bypass_and_orphan();
    test_overflow();
    test_stability();
    test_clear();
    test_reset_midburst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
